// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared types and defaults for the fetch program-counter generator.
//   state_t        : front-end run state (IDLE / RUN / HALT)
//   redir_class_t  : kind of redirect held or requested (NONE/JMP/BR/EXC/ERET)
//   cls_rank()     : priority class of a redirect kind; EXC and ERET share the
//                    top class, so a pending one of either is never displaced
//                    by the other.
// -----------------------------------------------------------------------------
package pc_gen_pkg;

    localparam int          DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0040_0004;
    localparam int          DEF_INC       = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        JMP,
        BR,
        EXC,
        ERET
    } redir_class_t;

    function automatic logic [1:0] cls_rank(input redir_class_t cls);
        case (cls)
            NONE:    cls_rank = 2'd0;
            JMP:     cls_rank = 2'd1;
            BR:      cls_rank = 2'd2;
            default: cls_rank = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
// Control/redirect bus between the pipeline and the fetch PC generator.
//   master : pipeline side -- drives ena/stall and the redirect requests,
//            observes the PC outputs.
//   slave  : pc_gen side.
// Signals:
//   ena, stall                       run enable / hazard hold
//   jmp_req/jmp_target               ID-stage jump
//   br_req/br_target                 EX-stage taken branch
//   exc_req/exc_epc, eret_req        exception entry / return
//   pc_out, pc_valid, pc_plus_inc    fetch address, liveness, address + INC
//   epc_out, redir_pending           saved exception PC, latched redirect flag
// -----------------------------------------------------------------------------
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);
    logic            ena;
    logic            stall;
    logic            jmp_req;
    logic [XLEN-1:0] jmp_target;
    logic            br_req;
    logic [XLEN-1:0] br_target;
    logic            exc_req;
    logic [XLEN-1:0] exc_epc;
    logic            eret_req;
    logic [XLEN-1:0] pc_out;
    logic            pc_valid;
    logic [XLEN-1:0] pc_plus_inc;
    logic [XLEN-1:0] epc_out;
    logic            redir_pending;

    modport master (
        output ena, stall, jmp_req, jmp_target, br_req, br_target,
               exc_req, exc_epc, eret_req,
        input  pc_out, pc_valid, pc_plus_inc, epc_out, redir_pending
    );

    modport slave (
        input  ena, stall, jmp_req, jmp_target, br_req, br_target,
               exc_req, exc_epc, eret_req,
        output pc_out, pc_valid, pc_plus_inc, epc_out, redir_pending
    );
endinterface

// File: rtl/pc_gen_redir_arb.sv
// -----------------------------------------------------------------------------
// pc_gen_redir_arb
// Combinational redirect picker. First selects the strongest new request
// (exc > eret > br > jmp), then compares it against the pending redirect:
// the new one wins only with a strictly higher class. The same result serves
// both as the PC target on an apply edge and as the next pending value on a
// capture edge, since "older wins ties" is the rule in both cases.
// All candidate targets are word-aligned (bits [1:0] cleared).
// Ports:
//   pend_cls/pend_tgt         currently latched redirect
//   *_req/*_tgt               new requests this cycle
//   win_cls/win_tgt           chosen redirect (NONE if nothing)
//   win_new                   chosen redirect came from a new request
// -----------------------------------------------------------------------------
module pc_gen_redir_arb
    import pc_gen_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  redir_class_t    pend_cls,
    input  logic [XLEN-1:0] pend_tgt,
    input  logic            exc_req,
    input  logic [XLEN-1:0] exc_tgt,
    input  logic            eret_req,
    input  logic [XLEN-1:0] eret_tgt,
    input  logic            br_req,
    input  logic [XLEN-1:0] br_tgt,
    input  logic            jmp_req,
    input  logic [XLEN-1:0] jmp_tgt,
    output redir_class_t    win_cls,
    output logic [XLEN-1:0] win_tgt,
    output logic            win_new
);
    localparam int NCAND = 4;

    // Index 0 is the highest priority candidate.
    logic [NCAND-1:0] req;
    logic [NCAND-1:0] hit;
    logic [XLEN-1:0]  raw_tgt [NCAND];
    logic [XLEN-1:0]  al_tgt  [NCAND];
    redir_class_t     cand_cls [NCAND];
    redir_class_t     new_cls;
    logic [XLEN-1:0]  new_tgt;

    assign req         = {jmp_req, br_req, eret_req, exc_req};
    assign raw_tgt[0]  = exc_tgt;
    assign raw_tgt[1]  = eret_tgt;
    assign raw_tgt[2]  = br_tgt;
    assign raw_tgt[3]  = jmp_tgt;
    assign cand_cls[0] = EXC;
    assign cand_cls[1] = ERET;
    assign cand_cls[2] = BR;
    assign cand_cls[3] = JMP;

    generate
        for (genvar gi = 0; gi < NCAND; gi++) begin : g_cand
            assign al_tgt[gi] = {raw_tgt[gi][XLEN-1:2], 2'b00};
            if (gi == 0) begin : g_top
                assign hit[gi] = req[gi];
            end else begin : g_rest
                assign hit[gi] = req[gi] & ~(|req[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        new_cls = NONE;
        new_tgt = '0;
        for (int i = 0; i < NCAND; i++) begin
            if (hit[i]) begin
                new_cls = cand_cls[i];
                new_tgt = al_tgt[i];
            end
        end
    end

    always_comb begin
        win_cls = pend_cls;
        win_tgt = pend_tgt;
        win_new = 1'b0;
        if (cls_rank(new_cls) > cls_rank(pend_cls)) begin
            win_cls = new_cls;
            win_tgt = new_tgt;
            win_new = 1'b1;
        end
    end
endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Fetch program-counter generator. Holds the fetch PC, advances it by INC
// each running cycle, and applies jump/branch/exception redirects. Any
// redirect that cannot be applied on its edge (stall, halted, idle) is
// latched and applied on the first running, unstalled edge.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pc_gen_if.slave (requests in, pc_out/pc_valid/pc_plus_inc/
//        epc_out/redir_pending out)
// Build option:
//   PC_GEN_EPC_EN  when defined, exc_req jumps to EXC_VEC and saves exc_epc,
//                  eret_req returns to the saved EPC. When undefined these
//                  inputs are ignored and epc_out reads 0.
// -----------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC),
    parameter int              INC       = DEF_INC
) (
    input  logic    clk,
    input  logic    rst,
    pc_gen_if.slave bus
);
    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    redir_class_t    pend_cls_reg, pend_cls_next;
    logic [XLEN-1:0] pend_tgt_reg, pend_tgt_next;
    logic [XLEN-1:0] pc_plus;
    redir_class_t    win_cls;
    logic [XLEN-1:0] win_tgt;
    logic            win_new;
    logic            exc_in;
    logic            eret_in;
    logic [XLEN-1:0] eret_tgt;
    logic            apply;

`ifdef PC_GEN_EPC_EN
    logic [XLEN-1:0] epc_reg, epc_next;

    assign exc_in   = bus.exc_req;
    assign eret_in  = bus.eret_req;
    assign eret_tgt = epc_reg;

    // EPC is saved whenever a new exception becomes the chosen redirect,
    // whether it is applied now or latched as pending.
    always_comb begin
        epc_next = epc_reg;
        if (win_new && (win_cls == EXC)) begin
            epc_next = bus.exc_epc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_reg <= '0;
        end else begin
            epc_reg <= epc_next;
        end
    end

    assign bus.epc_out = epc_reg;
`else
    logic unused_epc_ports;

    assign exc_in           = 1'b0;
    assign eret_in          = 1'b0;
    assign eret_tgt         = '0;
    assign unused_epc_ports = ^{bus.exc_req, bus.exc_epc, bus.eret_req, win_new};
    assign bus.epc_out      = '0;
`endif

    assign pc_plus = pc_reg + XLEN'(INC);

    pc_gen_redir_arb #(.XLEN(XLEN)) u_arb (
        .pend_cls (pend_cls_reg),
        .pend_tgt (pend_tgt_reg),
        .exc_req  (exc_in),
        .exc_tgt  (EXC_VEC),
        .eret_req (eret_in),
        .eret_tgt (eret_tgt),
        .br_req   (bus.br_req),
        .br_tgt   (bus.br_target),
        .jmp_req  (bus.jmp_req),
        .jmp_tgt  (bus.jmp_target),
        .win_cls  (win_cls),
        .win_tgt  (win_tgt),
        .win_new  (win_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_VEC;
            pend_cls_reg <= NONE;
            pend_tgt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pend_cls_reg <= pend_cls_next;
            pend_tgt_reg <= pend_tgt_next;
        end
    end

    // The PC only moves on an edge that starts in RUN with ena=1 and
    // stall=0; entering RUN (from IDLE or HALT) never advances it.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pend_cls_next = pend_cls_reg;
        pend_tgt_next = pend_tgt_reg;
        apply         = 1'b0;

        case (state_reg)
            IDLE:    if (bus.ena) state_next = RUN;
            RUN: begin
                if (!bus.ena) begin
                    state_next = HALT;
                end else if (!bus.stall) begin
                    apply = 1'b1;
                end
            end
            HALT:    if (bus.ena) state_next = RUN;
            default: state_next = IDLE;
        endcase

        if (apply) begin
            pend_cls_next = NONE;
            pend_tgt_next = '0;
            pc_next       = (win_cls != NONE) ? win_tgt : pc_plus;
        end else begin
            pend_cls_next = win_cls;
            pend_tgt_next = win_tgt;
        end
    end

    assign bus.pc_out        = pc_reg;
    assign bus.pc_valid      = (state_reg == RUN);
    assign bus.pc_plus_inc   = pc_plus;
    assign bus.redir_pending = (pend_cls_reg != NONE);
endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
// Self-checking bench for pc_gen. Each scenario task drives inputs and pushes
// the expected post-edge outputs to exp_q; every clock the observed outputs
// are pushed to got_q, and the task pops and compares both at its end.
// Expectations adapt to whether PC_GEN_EPC_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_gen;

`ifdef PC_GEN_EPC_EN
    localparam bit EPC_EN = 1'b1;
`else
    localparam bit EPC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] plus;
        logic        valid;
        logic        pend;
        logic [31:0] epc;
    } obs_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    obs_t exp_q[$];
    obs_t got_q[$];

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t ex(input logic [31:0] pc, input logic v,
                                input logic p, input logic [31:0] epc);
        obs_t o;
        o.pc    = pc;
        o.plus  = pc + 32'd4;
        o.valid = v;
        o.pend  = p;
        o.epc   = epc;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc    = bus.pc_out;
        o.plus  = bus.pc_plus_inc;
        o.valid = bus.pc_valid;
        o.pend  = bus.redir_pending;
        o.epc   = bus.epc_out;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pc=%h plus=%h valid=%b pend=%b epc=%h",
                         o.pc, o.plus, o.valid, o.pend, o.epc);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        got_q.push_back(sample());
    endtask

    task automatic clr_req();
        bus.jmp_req    = 1'b0;
        bus.jmp_target = '0;
        bus.br_req     = 1'b0;
        bus.br_target  = '0;
        bus.exc_req    = 1'b0;
        bus.exc_epc    = '0;
        bus.eret_req   = 1'b0;
    endtask

    // Expected values shared by several scenarios.
    localparam logic [31:0] P0 = EPC_EN ? 32'h0040_0004 : 32'h0040_0100;
    localparam logic [31:0] EA = EPC_EN ? 32'h0040_0050 : 32'h0;
    localparam logic [31:0] EB = EPC_EN ? 32'h0040_0010 : 32'h0;
    localparam logic [31:0] E  = EPC_EN ? 32'h0040_0020 : 32'h0;

    task automatic test_reset();
        obs_t e, g;
        rst = 1'b1; bus.ena = 1'b0; bus.stall = 1'b0; clr_req();
        exp_q.push_back(ex(32'h0040_0000, 0, 0, 0)); tick();
        exp_q.push_back(ex(32'h0040_0000, 0, 0, 0)); tick();
        rst = 1'b0;
        exp_q.push_back(ex(32'h0040_0000, 0, 0, 0)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_sequential();
        obs_t e, g;
        bus.ena = 1'b1;
        exp_q.push_back(ex(32'h0040_0000, 1, 0, 0)); tick();
        exp_q.push_back(ex(32'h0040_0004, 1, 0, 0)); tick();
        exp_q.push_back(ex(32'h0040_0008, 1, 0, 0)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sequential[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_halt();
        obs_t e, g;
        bus.ena = 1'b0;
        exp_q.push_back(ex(32'h0040_0008, 0, 0, 0)); tick();
        exp_q.push_back(ex(32'h0040_0008, 0, 0, 0)); tick();
        bus.ena = 1'b1;
        exp_q.push_back(ex(32'h0040_0008, 1, 0, 0)); tick();
        exp_q.push_back(ex(32'h0040_000C, 1, 0, 0)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL halt[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_stalled_branch();
        obs_t e, g;
        bus.stall = 1'b1; bus.br_req = 1'b1; bus.br_target = 32'h0040_0100;
        exp_q.push_back(ex(32'h0040_000C, 1, 1, 0)); tick();
        clr_req();
        exp_q.push_back(ex(32'h0040_000C, 1, 1, 0)); tick();
        exp_q.push_back(ex(32'h0040_000C, 1, 1, 0)); tick();
        bus.stall = 1'b0;
        exp_q.push_back(ex(32'h0040_0100, 1, 0, 0)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stalled_branch[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_same_cycle();
        obs_t e, g;
        bus.jmp_req = 1'b1; bus.jmp_target = 32'h0040_0200;
        bus.br_req  = 1'b1; bus.br_target  = 32'h0040_0300;
        exp_q.push_back(ex(32'h0040_0300, 1, 0, 0)); tick();
        clr_req();
        exp_q.push_back(ex(32'h0040_0304, 1, 0, 0)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL same_cycle[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_pending_priority();
        obs_t e, g;
        bus.stall = 1'b1; bus.br_req = 1'b1; bus.br_target = 32'h0040_0100;
        exp_q.push_back(ex(32'h0040_0304, 1, 1, 0)); tick();
        clr_req(); bus.jmp_req = 1'b1; bus.jmp_target = 32'h0040_0200;
        exp_q.push_back(ex(32'h0040_0304, 1, 1, 0)); tick();
        clr_req(); bus.exc_req = 1'b1; bus.exc_epc = 32'h0040_0050;
        exp_q.push_back(ex(32'h0040_0304, 1, 1, EA)); tick();
        clr_req(); bus.stall = 1'b0;
        exp_q.push_back(ex(P0, 1, 0, EA)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL pending_priority[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_exception();
        obs_t e, g;
        bus.exc_req = 1'b1; bus.exc_epc = 32'h0040_0010;
        exp_q.push_back(ex(EPC_EN ? 32'h0040_0004 : P0 + 32'd4, 1, 0, EB)); tick();
        clr_req(); bus.eret_req = 1'b1;
        exp_q.push_back(ex(EPC_EN ? 32'h0040_0010 : P0 + 32'd8, 1, 0, EB)); tick();
        clr_req();
        bus.exc_req = 1'b1; bus.exc_epc = 32'h0040_0020; bus.eret_req = 1'b1;
        bus.br_req  = 1'b1; bus.br_target = 32'h0040_0900;
        exp_q.push_back(ex(EPC_EN ? 32'h0040_0004 : 32'h0040_0900, 1, 0, E)); tick();
        clr_req();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL exception[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        bus.jmp_req = 1'b1; bus.jmp_target = 32'h0040_0400;
        exp_q.push_back(ex(32'h0040_0400, 1, 0, E)); tick();
        clr_req(); bus.br_req = 1'b1; bus.br_target = 32'h0040_0500;
        exp_q.push_back(ex(32'h0040_0500, 1, 0, E)); tick();
        clr_req(); bus.jmp_req = 1'b1; bus.jmp_target = 32'h0040_0601;
        exp_q.push_back(ex(32'h0040_0600, 1, 0, E)); tick();
        clr_req();
        exp_q.push_back(ex(32'h0040_0604, 1, 0, E)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_halt_redirect();
        obs_t e, g;
        bus.ena = 1'b0; bus.br_req = 1'b1; bus.br_target = 32'h0040_0700;
        exp_q.push_back(ex(32'h0040_0604, 0, 1, E)); tick();
        clr_req(); bus.ena = 1'b1;
        exp_q.push_back(ex(32'h0040_0604, 1, 1, E)); tick();
        exp_q.push_back(ex(32'h0040_0700, 1, 0, E)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL halt_redirect[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_wrap_align();
        obs_t e, g;
        bus.jmp_req = 1'b1; bus.jmp_target = 32'hFFFF_FFFD;
        exp_q.push_back(ex(32'hFFFF_FFFC, 1, 0, E)); tick();
        clr_req();
        exp_q.push_back(ex(32'h0000_0000, 1, 0, E)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL wrap_align[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t e, g;
        bus.stall = 1'b1; bus.br_req = 1'b1; bus.br_target = 32'h0040_0800;
        exp_q.push_back(ex(32'h0000_0000, 1, 1, E)); tick();
        clr_req();
        #2 rst = 1'b1;
        #1 got_q.push_back(sample());
        exp_q.push_back(ex(32'h0040_0000, 0, 0, 0));
        exp_q.push_back(ex(32'h0040_0000, 0, 0, 0)); tick();
        rst = 1'b0;
        exp_q.push_back(ex(32'h0040_0000, 1, 0, 0)); tick();
        bus.stall = 1'b0;
        exp_q.push_back(ex(32'h0040_0004, 1, 0, 0)); tick();
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid_stall[%0d] got %s want %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.ena = 1'b0;
        bus.stall = 1'b0;
        clr_req();
        test_reset();
        test_sequential();
        test_halt();
        test_stalled_branch();
        test_same_cycle();
        test_pending_priority();
        test_exception();
        test_back_to_back();
        test_halt_redirect();
        test_wrap_align();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
